// File: rtl/csa_pkg.sv
// Shared constants, phase encoding and beat-packing helper for the CSA output packer.
package csa_pkg;

   localparam int unsigned CSA_CALC_OUT_WIDTH = 48;
   localparam int unsigned AXIS_DATA_WIDTH    = 32;

   typedef enum logic [1:0] {
      PH_LO  = 2'd0,
      PH_MID = 2'd1,
      PH_HI  = 2'd2
   } phase_t;

   // Two 48-bit results H (older) and H1 map onto three 32-bit beats.
   localparam int unsigned LO_MSB     = 31;
   localparam int unsigned MID_H_LSB  = 32;
   localparam int unsigned MID_H1_MSB = 15;
   localparam int unsigned HI_LSB     = 16;

   function automatic logic [AXIS_DATA_WIDTH-1:0] pack_beat(
      input phase_t                        ph,
      input logic [CSA_CALC_OUT_WIDTH-1:0] h,
      input logic [CSA_CALC_OUT_WIDTH-1:0] h1
   );
      logic [AXIS_DATA_WIDTH-1:0] b;
      case (ph)
         PH_LO:   b = h[LO_MSB:0];
         PH_MID:  b = {h1[MID_H1_MSB:0], h[CSA_CALC_OUT_WIDTH-1:MID_H_LSB]};
         default: b = h[CSA_CALC_OUT_WIDTH-1:HI_LSB];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/csa_result_fifo.sv
// Single-clock result FIFO exposing the head and head+1 entries for the beat packer.
module csa_result_fifo
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       csa_calc_clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [WIDTH-1:0]           head1,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage needs no reset: entries are only observed once written.
   always_ff @(posedge csa_calc_clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge csa_calc_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign head1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/csa_out_axis_packer.sv
// Buffers 48-bit CSA results and repacks each pair into three 32-bit AXI-Stream beats.
module csa_out_axis_packer
   import csa_pkg::*;
#(
   parameter int unsigned CSA_CALC_OUT_WIDTH = 48,
   parameter int unsigned AXIS_DATA_WIDTH    = 32,
   parameter int unsigned FIFO_DEPTH         = 8,
   parameter int unsigned RESULTS_PER_PACKET = 8
) (
   input  logic                          csa_calc_clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          csa_out_wen,
   input  logic [CSA_CALC_OUT_WIDTH-1:0] csa_out_wdata,
   output logic                          csa_out_error_full,
   output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          overflow,
   output logic [31:0]                   result_count,
   output logic [31:0]                   beat_count
);

   if (CSA_CALC_OUT_WIDTH != csa_pkg::CSA_CALC_OUT_WIDTH ||
       AXIS_DATA_WIDTH != csa_pkg::AXIS_DATA_WIDTH) begin : g_bad_width
      $error("csa_out_axis_packer: widths are fixed at 48 in / 32 out");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("csa_out_axis_packer: FIFO_DEPTH must be a power of two >= 2");
   end
   if (RESULTS_PER_PACKET < 2 || (RESULTS_PER_PACKET % 2) != 0) begin : g_bad_packet
      $error("csa_out_axis_packer: RESULTS_PER_PACKET must be even and >= 2");
   end

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PAIRS = RESULTS_PER_PACKET / 2;
   localparam int unsigned PCW   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   logic [CSA_CALC_OUT_WIDTH-1:0] head;
   logic [CSA_CALC_OUT_WIDTH-1:0] head1;
   logic [AW:0]                   count;
   logic [AW:0]                   cnt_after_pop;
   phase_t                        phase;
   phase_t                        phase_nxt;
   logic [PCW-1:0]                pair_cnt;
   logic                          tvalid_r;
   logic                          tvalid_nxt;
   logic                          full;
   logic                          push;
   logic                          pop;
   logic                          hs;
   logic                          last_pair;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign push      = csa_out_wen && !full;
   assign hs        = tvalid_r && m_axis_tready;
   assign pop       = hs && (phase != PH_LO);
   assign last_pair = (pair_cnt == PCW'(PAIRS - 1));

   csa_result_fifo #(
      .WIDTH (CSA_CALC_OUT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .csa_calc_clk (csa_calc_clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .push         (push),
      .push_data    (csa_out_wdata),
      .pop          (pop),
      .head         (head),
      .head1        (head1),
      .count        (count)
   );

   // Next tvalid ignores this cycle's write, giving one cycle of write-to-valid
   // latency; pops are accounted for, so tvalid never falls without a handshake.
   always_comb begin
      phase_nxt = phase;
      if (hs) begin
         case (phase)
            PH_LO:   phase_nxt = PH_MID;
            PH_MID:  phase_nxt = PH_HI;
            default: phase_nxt = PH_LO;
         endcase
      end
      cnt_after_pop = count - {{AW{1'b0}}, pop};
      if (phase_nxt == PH_HI) begin
         tvalid_nxt = (cnt_after_pop >= (AW+1)'(1));
      end else begin
         tvalid_nxt = (cnt_after_pop >= (AW+1)'(2));
      end
   end

   always_ff @(posedge csa_calc_clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= PH_LO;
         tvalid_r     <= 1'b0;
         pair_cnt     <= '0;
         overflow     <= 1'b0;
         result_count <= '0;
         beat_count   <= '0;
      end else if (clr) begin
         phase        <= PH_LO;
         tvalid_r     <= 1'b0;
         pair_cnt     <= '0;
         overflow     <= 1'b0;
         result_count <= '0;
         beat_count   <= '0;
      end else begin
         phase    <= phase_nxt;
         tvalid_r <= tvalid_nxt;
         if (hs && phase == PH_HI) begin
            pair_cnt <= last_pair ? '0 : pair_cnt + PCW'(1);
         end
         if (csa_out_wen && full) begin
            overflow <= 1'b1;
         end
         if (push) begin
            result_count <= result_count + 32'd1;
         end
         if (hs) begin
            beat_count <= beat_count + 32'd1;
         end
      end
   end

   assign csa_out_error_full = full;
   assign m_axis_tvalid      = tvalid_r;
   assign m_axis_tdata       = tvalid_r ? pack_beat(phase, head, head1) : '0;
   assign m_axis_tlast       = tvalid_r && (phase == PH_HI) && last_pair;

endmodule

// File: tb/tb_csa_out_axis_packer.sv
// Self-checking bench for csa_out_axis_packer: table vectors plus scoreboarded stream.
module tb_csa_out_axis_packer;

   localparam int RPP   = 8;
   localparam int PAIRS = RPP / 2;

   logic        csa_calc_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        csa_out_wen = 1'b0;
   logic [47:0] csa_out_wdata = '0;
   logic        csa_out_error_full;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        overflow;
   logic [31:0] result_count;
   logic [31:0] beat_count;

   csa_out_axis_packer #(
      .FIFO_DEPTH         (8),
      .RESULTS_PER_PACKET (RPP)
   ) dut (
      .csa_calc_clk       (csa_calc_clk),
      .rst_n              (rst_n),
      .clr                (clr),
      .csa_out_wen        (csa_out_wen),
      .csa_out_wdata      (csa_out_wdata),
      .csa_out_error_full (csa_out_error_full),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .overflow           (overflow),
      .result_count       (result_count),
      .beat_count         (beat_count)
   );

   always #5 csa_calc_clk = ~csa_calc_clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic [47:0] a;
      logic [47:0] b;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   beat_t       exp_q[$];
   vec_t        vecs[4];
   int          checks = 0;
   int          failures = 0;
   int          mdl_pair = 0;
   bit          pend_v = 1'b0;
   logic [47:0] pend = '0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge csa_calc_clk);
      #1;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), 32'($urandom)};
   endfunction

   task automatic push_pair(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      beat_t b;
      b.last = 1'b0;
      b.data = e0; exp_q.push_back(b);
      b.data = e1; exp_q.push_back(b);
      b.data = e2;
      b.last = (mdl_pair == PAIRS - 1);
      exp_q.push_back(b);
      mdl_pair = (mdl_pair + 1) % PAIRS;
   endtask

   // Beats of a pair as the stream is meant to carry them: A low word,
   // then B low half over A high half, then B high word.
   task automatic model_push(input logic [47:0] d);
      if (!pend_v) begin
         pend   = d;
         pend_v = 1'b1;
      end else begin
         push_pair(pend[31:0], {d[15:0], pend[47:32]}, d[47:16]);
         pend_v = 1'b0;
      end
   endtask

   task automatic drive_wen(input logic [47:0] d);
      csa_out_wen   = 1'b1;
      csa_out_wdata = d;
      tick();
   endtask

   task automatic wr(input logic [47:0] d, input bit acc);
      if (acc) model_push(d);
      drive_wen(d);
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic soft_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_q.delete();
      pend_v   = 1'b0;
      mdl_pair = 0;
   endtask

   // Stream monitor: sampled mid-cycle, one sample per clock.
   always @(negedge csa_calc_clk) begin
      if (!rst_n || clr) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("hold_data", 64'(m_axis_tdata), 64'(prev_data));
            chk("hold_last", 64'(m_axis_tlast), 64'(prev_last));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
               chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
            end
            prev_stall = 1'b0;
         end else if (m_axis_tvalid) begin
            prev_stall = 1'b1;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit full_seen;

      vecs[0] = '{48'h0000_1111_2222, 48'h3333_4444_5555, 32'h1111_2222, 32'h5555_0000, 32'h3333_4444};
      vecs[1] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000};
      vecs[2] = '{48'h0123_4567_89AB, 48'hCDEF_0011_2233, 32'h4567_89AB, 32'h2233_0123, 32'hCDEF_0011};
      vecs[3] = '{48'hA5A5_5A5A_F00F, 48'h1234_5678_9ABC, 32'h5A5A_F00F, 32'h9ABC_A5A5, 32'h1234_5678};

      // Reset and idle
      repeat (3) tick();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_full", 64'(csa_out_error_full), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("idle_results", 64'(result_count), 64'd0);
      chk("idle_beats", 64'(beat_count), 64'd0);
      chk("idle_overflow", 64'(overflow), 64'd0);

      // Table-driven pairs; four pairs close one packet
      m_axis_tready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         drive_wen(vecs[v].a);
         drive_wen(vecs[v].b);
         csa_out_wen = 1'b0;
         push_pair(vecs[v].e0, vecs[v].e1, vecs[v].e2);
         if (v == 0) begin
            chk("latency_edge_n", 64'(m_axis_tvalid), 64'd0);
            tick();
            chk("latency_edge_n1", 64'(m_axis_tvalid), 64'd1);
         end
         drain(20);
         if (v == 0) begin
            chk("pair_beats", 64'(beat_count), 64'd3);
            chk("pair_results", 64'(result_count), 64'd2);
         end
      end
      chk("pkt_beats", 64'(beat_count), 64'd12);
      chk("pkt_results", 64'(result_count), 64'd8);

      // Sustained 2/3 write rate: never full, all beats in order
      full_seen = 1'b0;
      for (int p = 0; p < 6; p++) begin
         wr(rnd48(), 1'b1);
         full_seen |= csa_out_error_full;
         wr(rnd48(), 1'b1);
         full_seen |= csa_out_error_full;
         csa_out_wen = 1'b0;
         tick();
         full_seen |= csa_out_error_full;
      end
      drain(60);
      chk("no_throttle", 64'(full_seen), 64'd0);
      chk("rate_beats", 64'(beat_count), 64'd30);

      // Backpressure: fill with tready low, data must hold
      m_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("bp_not_full", 64'(csa_out_error_full), 64'd0);
         wr(rnd48(), 1'b1);
      end
      csa_out_wen = 1'b0;
      chk("bp_full", 64'(csa_out_error_full), 64'd1);
      repeat (12) tick();
      chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("bp_head", 64'(m_axis_tdata), 64'(exp_q[0].data));
      m_axis_tready = 1'b1;
      drain(60);
      chk("bp_overflow", 64'(overflow), 64'd0);
      chk("bp_results", 64'(result_count), 64'd28);

      // Overflow: a write while full is dropped
      soft_clear();
      chk("clr1_results", 64'(result_count), 64'd0);
      chk("clr1_beats", 64'(beat_count), 64'd0);
      m_axis_tready = 1'b0;
      for (int i = 0; i < 8; i++) wr(rnd48(), 1'b1);
      wr(48'hBAD0_BAD0_BAD0, 1'b0);
      csa_out_wen = 1'b0;
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_results", 64'(result_count), 64'd8);
      chk("ovf_full", 64'(csa_out_error_full), 64'd1);
      m_axis_tready = 1'b1;
      drain(60);
      repeat (3) tick();
      chk("ovf_no_extra", 64'(m_axis_tvalid), 64'd0);
      chk("ovf_beats", 64'(beat_count), 64'd12);
      soft_clear();
      chk("clr_overflow", 64'(overflow), 64'd0);
      chk("clr_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("clr_results", 64'(result_count), 64'd0);
      chk("clr_beats", 64'(beat_count), 64'd0);

      // Asynchronous reset in the middle of a pair
      m_axis_tready = 1'b0;
      wr(rnd48(), 1'b1);
      wr(rnd48(), 1'b1);
      csa_out_wen = 1'b0;
      tick();
      chk("ar_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      chk("ar_phase1_valid", 64'(m_axis_tvalid), 64'd1);
      chk("ar_phase1_data", 64'(m_axis_tdata), 64'(exp_q[0].data));
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tvalid_async", 64'(m_axis_tvalid), 64'd0);
      chk("ar_tdata_async", 64'(m_axis_tdata), 64'd0);
      exp_q.delete();
      pend_v   = 1'b0;
      mdl_pair = 0;
      tick();
      rst_n = 1'b1;
      tick();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 2 * PAIRS; i++) wr(rnd48(), 1'b1);
      csa_out_wen = 1'b0;
      drain(80);
      chk("ar_beats", 64'(beat_count), 64'd12);
      chk("ar_results", 64'(result_count), 64'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
